act_stream: RTL and testbench

ACT_STREAM -- requirements
Module: act_stream

---
 rtl/act_pkg.sv | 37 +++
 rtl/act_lane.sv | 42 ++++
 rtl/act_stream.sv | 150 +++++++++++++++
 tb/tb_act_stream.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// act_stream shared types and helpers.
// Mode encoding, counter width and ReLU6 ceiling.
package act_pkg;

   typedef enum logic [1:0] {
      ACT_BYPASS = 2'b00,
      ACT_RELU   = 2'b01,
      ACT_LEAKY  = 2'b10,
      ACT_RELU6  = 2'b11
   } act_mode_e;

   localparam int CNT_W = 16;

   // 6.0 in fixed point, or the largest positive value when 6.0 does not fit.
   function automatic logic [63:0] relu6_ceil(input int dw, input int fb);
      logic [63:0] maxv;
      maxv = (64'd1 << (dw - 1)) - 64'd1;
      if (fb + 3 > dw - 1) begin
         return maxv;
      end
      return 64'd6 << fb;
   endfunction

   // Saturating add used by the negative-element counter.
   function automatic logic [CNT_W-1:0] sat_add(
      input logic [CNT_W-1:0] a,
      input logic [CNT_W:0]   b
   );
      logic [CNT_W:0] s;
      s = {1'b0, a} + b;
      if (s[CNT_W]) begin
         return '1;
      end
      return s[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/act_lane.sv
// act_lane: one-element activation function.
// Purely combinational, replicated once per lane.
module act_lane
   import act_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int LEAK_SHIFT = 3
) (
   input  act_mode_e                     mode,
   input  logic signed [DATA_WIDTH-1:0]  x,
   output logic signed [DATA_WIDTH-1:0]  y
);

   localparam logic [63:0] CEIL_L = relu6_ceil(DATA_WIDTH, FRAC_BITS);
   localparam logic signed [DATA_WIDTH-1:0] CEIL = CEIL_L[DATA_WIDTH-1:0];

   logic neg;

   assign neg = x[DATA_WIDTH-1];

   // Select the activation for this element.
   always_comb begin
      y = x;
      unique case (mode)
         ACT_BYPASS: y = x;
         ACT_RELU:   y = neg ? '0 : x;
         ACT_LEAKY:  y = neg ? (x >>> LEAK_SHIFT) : x;
         ACT_RELU6: begin
            if (neg) begin
               y = '0;
            end else if (x > CEIL) begin
               y = CEIL;
            end else begin
               y = x;
            end
         end
         default:    y = x;
      endcase
   end

endmodule

// File: rtl/act_stream.sv
// act_stream: two-stage streaming activation unit.
// Per-frame mode latch and negative-element counting.
module act_stream
   import act_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 4,
   parameter int FRAC_BITS  = 8,
   parameter int LEAK_SHIFT = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [1:0]                  mode_i,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*DATA_WIDTH-1:0] in_data,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DATA_WIDTH-1:0] out_data,
   output logic                        out_last,
   output logic                        frame_done,
   output logic [15:0]                 neg_count
);

   localparam int DW = DATA_WIDTH;
   localparam int W  = LANES * DATA_WIDTH;

   logic             s1_valid;
   logic             s1_ready;
   logic [W-1:0]     s1_data;
   logic             s1_last;
   act_mode_e        s1_mode;
   logic [CNT_W-1:0] s1_cnt;

   logic             s2_valid;
   logic             s2_ready;
   logic [CNT_W-1:0] s2_cnt;

   logic             in_frame;
   act_mode_e        frame_mode;
   logic [CNT_W-1:0] run_cnt;
   logic [CNT_W-1:0] neg_hold;

   logic             in_fire;
   logic             out_fire;
   act_mode_e        beat_mode;
   logic [CNT_W-1:0] beat_base;
   logic [CNT_W-1:0] beat_cnt;
   logic [CNT_W:0]   pop;
   logic [W-1:0]     act_data;

   assign s2_ready  = !s2_valid || out_ready;
   assign s1_ready  = !s1_valid || s2_ready;
   assign in_ready  = s1_ready;
   assign in_fire   = in_valid && s1_ready;
   assign out_fire  = s2_valid && out_ready;
   assign out_valid = s2_valid;

   // The frame total is visible in the same cycle its last beat leaves.
   assign frame_done = out_fire && out_last;
   assign neg_count  = frame_done ? s2_cnt : neg_hold;

   // First beat of a frame takes mode_i and restarts the count.
   assign beat_mode = in_frame ? frame_mode : act_mode_e'(mode_i);
   assign beat_base = in_frame ? run_cnt : '0;
   assign beat_cnt  = sat_add(beat_base, pop);

   // Count sign bits across the incoming beat.
   always_comb begin
      pop = '0;
      for (int i = 0; i < LANES; i++) begin
         pop = pop + {{CNT_W{1'b0}}, in_data[i*DW+DW-1]};
      end
   end

   // Frame tracking: mode latch and running negative count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_frame   <= 1'b0;
         frame_mode <= ACT_BYPASS;
         run_cnt    <= '0;
      end else if (in_fire) begin
         in_frame   <= !in_last;
         frame_mode <= beat_mode;
         run_cnt    <= beat_cnt;
      end
   end

   // Stage 1: capture the beat with its mode and count snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_last  <= 1'b0;
         s1_mode  <= ACT_BYPASS;
         s1_cnt   <= '0;
      end else begin
         if (s1_ready) begin
            s1_valid <= in_valid;
         end
         if (in_fire) begin
            s1_data <= in_data;
            s1_last <= in_last;
            s1_mode <= beat_mode;
            s1_cnt  <= beat_cnt;
         end
      end
   end

   // Per-lane activation of the stage-1 beat.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      act_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .FRAC_BITS  (FRAC_BITS),
         .LEAK_SHIFT (LEAK_SHIFT)
      ) u_lane (
         .mode (s1_mode),
         .x    (s1_data[g*DW +: DW]),
         .y    (act_data[g*DW +: DW])
      );
   end

   // Stage 2: output register, held while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         out_data <= '0;
         out_last <= 1'b0;
         s2_cnt   <= '0;
      end else if (s2_ready) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= act_data;
            out_last <= s1_last;
            s2_cnt   <= s1_cnt;
         end
      end
   end

   // Keep the last reported frame total until the next frame ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_hold <= '0;
      end else if (frame_done) begin
         neg_hold <= s2_cnt;
      end
   end

endmodule

// File: tb/tb_act_stream.sv
// tb_act_stream: random and directed stimulus for act_stream.
// Scoreboard model computes expectations from the activation rules.
module tb_act_stream;
   import act_pkg::*;

   localparam int DW = 16;
   localparam int LN = 4;
   localparam int W  = DW * LN;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   mode_i;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_last;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         frame_done;
   logic [15:0]  neg_count;

   act_stream u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode_i     (mode_i),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .frame_done (frame_done),
      .neg_count  (neg_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] pack4(input int a, input int b,
                                          input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   // Reference activation with plain integer arithmetic.
   function automatic int act_ref(input int x, input int m);
      case (m)
         1: return (x < 0) ? 0 : x;
         2: return (x < 0) ? -((-x + 7) / 8) : x;
         3: return (x < 0) ? 0 : ((x > 1536) ? 1536 : x);
         default: return x;
      endcase
   endfunction

   function automatic logic [W-1:0] act_vec(input logic [W-1:0] v,
                                            input int m);
      logic [W-1:0] r;
      int x;
      r = '0;
      for (int i = 0; i < LN; i++) begin
         x = int'($signed(v[i*DW +: DW]));
         r[i*DW +: DW] = 16'(act_ref(x, m));
      end
      return r;
   endfunction

   function automatic int negs(input logic [W-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < LN; i++) begin
         if (int'($signed(v[i*DW +: DW])) < 0) n++;
      end
      return n;
   endfunction

   typedef struct {
      logic [W-1:0] data;
      logic         last;
      int           cnt;
   } exp_t;

   exp_t         q[$];
   bit           m_in_frame = 0;
   int           m_mode = 0;
   int           m_cnt = 0;
   int           last_total = 0;
   bit           stalled = 0;
   logic [W-1:0] held_data;
   logic         held_last;

   int bp = 0;
   bit force_stall = 0;

   // Downstream backpressure generator.
   always @(posedge clk) begin
      #1;
      out_ready = force_stall ? 1'b0 : ($urandom_range(99) >= bp);
   end

   // Scoreboard: model inputs, compare outputs, watch stall stability.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q.delete();
         m_in_frame = 0;
         m_mode     = 0;
         m_cnt      = 0;
         last_total = 0;
         stalled    = 0;
      end else begin
         if (stalled) begin
            check("hold_valid", 64'(out_valid), 1);
            check("hold_data", 64'(out_data), 64'(held_data));
            check("hold_last", 64'(out_last), 64'(held_last));
         end
         if (out_valid && out_ready) begin
            check("beat_expected", 64'(q.size() != 0), 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               check("out_data", 64'(out_data), 64'(e.data));
               check("out_last", 64'(out_last), 64'(e.last));
               check("frame_done", 64'(frame_done), 64'(e.last));
               if (e.last) begin
                  check("neg_count", 64'(neg_count), 64'(e.cnt));
                  last_total = e.cnt;
               end
            end
         end else begin
            check("frame_done_idle", 64'(frame_done), 0);
         end
         if (!frame_done) begin
            check("neg_hold", 64'(neg_count), 64'(last_total));
         end
         stalled   = out_valid && !out_ready;
         held_data = out_data;
         held_last = out_last;
         if (in_valid && in_ready) begin
            if (!m_in_frame) begin
               m_mode = int'(mode_i);
               m_cnt  = 0;
            end
            m_cnt = m_cnt + negs(in_data);
            if (m_cnt > 65535) m_cnt = 65535;
            e.data = act_vec(in_data, m_mode);
            e.last = in_last;
            e.cnt  = m_cnt;
            q.push_back(e);
            m_in_frame = !in_last;
         end
      end
   end

   task automatic send(input logic [W-1:0] d, input logic l,
                       input logic [1:0] m);
      bit acc;
      int t;
      acc = 0;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      mode_i   = m;
      while (!acc && t < 100) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      in_valid = 1'b0;
      check("send_accepted", 64'(acc), 1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      force_stall = 0;
      bp = 0;
      while ((q.size() != 0 || out_valid) && t < 200) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("drain_empty", 64'(q.size()), 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      mode_i   = 2'b00;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;

      check("rst_in_ready", 64'(in_ready), 1);
      check("rst_out_valid", 64'(out_valid), 0);
      check("rst_out_data", 64'(out_data), 0);
      check("rst_out_last", 64'(out_last), 0);
      check("rst_frame_done", 64'(frame_done), 0);
      check("rst_neg_count", 64'(neg_count), 0);
      @(posedge clk);
      #1;

      // ReLU one-beat frame, latency and same-cycle frame total.
      send(pack4(-5, 0, 7, -32768), 1'b1, 2'b01);
      check("relu_lat1", 64'(out_valid), 0);
      @(posedge clk);
      #1;
      check("relu_valid", 64'(out_valid), 1);
      check("relu_data", 64'(out_data), 64'(pack4(0, 0, 7, 0)));
      check("relu_done", 64'(frame_done), 1);
      check("relu_cnt", 64'(neg_count), 2);

      // Leaky: -1 stays -1.
      send(pack4(-64, 64, -1, 0), 1'b1, 2'b10);
      @(posedge clk);
      #1;
      check("leaky_data", 64'(out_data), 64'(pack4(-8, 64, -1, 0)));

      // ReLU6 clamp.
      send(pack4(16'h0700, 16'h05FF, -1, 16'h7FFF), 1'b1, 2'b11);
      @(posedge clk);
      #1;
      check("relu6_data", 64'(out_data),
            64'(pack4(16'h0600, 16'h05FF, 0, 16'h0600)));

      // Stall mid-stream.
      drain();
      force_stall = 1;
      @(posedge clk);
      @(posedge clk);
      #1;
      send(pack4(-1, 2, -3, 4), 1'b0, 2'b01);
      send(pack4(5, -6, 7, -8), 1'b0, 2'b00);
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 0);
      check("stall_out_valid", 64'(out_valid), 1);
      repeat (4) @(posedge clk);
      #1;
      force_stall = 0;
      send(pack4(-9, -10, 11, 12), 1'b1, 2'b10);
      drain();

      // Mode change mid-frame is ignored until the next frame.
      send(pack4(-100, 100, -2, 3), 1'b0, 2'b01);
      send(pack4(-7, 8, -9, 10), 1'b0, 2'b00);
      send(pack4(-11, 12, 13, -14), 1'b1, 2'b00);
      send(pack4(-15, 16, -17, 18), 1'b1, 2'b00);
      drain();

      // Reset with two beats in flight.
      send(pack4(-1, -1, -1, -1), 1'b0, 2'b01);
      send(pack4(-2, -2, -2, -2), 1'b0, 2'b01);
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", 64'(out_valid), 0);
      check("rst_mid_done", 64'(frame_done), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      check("rst_mid_in_ready", 64'(in_ready), 1);
      send(pack4(-1, -2, 3, 4), 1'b1, 2'b01);
      @(posedge clk);
      #1;
      check("post_rst_done", 64'(frame_done), 1);
      check("post_rst_cnt", 64'(neg_count), 2);
      check("post_rst_data", 64'(out_data), 64'(pack4(0, 0, 3, 4)));
      drain();

      // Random traffic with backpressure.
      bp = 30;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
         end
         send({$urandom, $urandom}, ($urandom_range(3) == 0),
              2'($urandom_range(3)));
      end
      send({$urandom, $urandom}, 1'b1, 2'($urandom_range(3)));
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
